hack_rom_loader: RTL and testbench

//  Boot-time program loader for the Hack Computer: receives a framed byte stream from an upstream

---
 rtl/hack_rom_loader_if.sv | 11 +
 rtl/hack_rom_loader.sv | 118 +++++++++++
 tb/tb_hack_rom_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hack_rom_loader_if.sv
// hack_rom_loader_if: byte-receive handshake (rx_valid/rx_data/rx_ready) and ROM write port (rom_we/rom_addr/rom_wdata)
interface hack_rom_loader_if #(parameter int ADDR_WIDTH = 15) ();
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_wdata;
  modport master (output rx_valid, rx_data, input rx_ready, rom_we, rom_addr, rom_wdata);
  modport slave (input rx_valid, rx_data, output rx_ready, rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: framed byte stream to ROM writes; ports clock/reset, bus (rx in, rom out), cpu_reset/done/error/words_loaded status
module hack_rom_loader #(
  parameter int         ADDR_WIDTH = 15,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  hack_rom_loader_if.slave    bus,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR} state_t;
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d, len_new;
  logic [7:0]            hi_q, hi_d, sum_q, sum_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]           rom_wdata_q, rom_wdata_d;
  logic [ADDR_WIDTH:0]   words_q, words_d, words_inc;
  logic                  cpu_reset_q, cpu_reset_d, done_q, done_d, error_q, error_d;
  logic                  take, chk_ok, too_long;
  assign bus.rx_ready  = state_q != RUN && state_q != ERROR;
  assign take          = bus.rx_valid && bus.rx_ready;
  assign len_new       = {len_q[15:8], bus.rx_data};
  assign words_inc     = words_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign chk_ok        = bus.rx_data == sum_q;
  assign too_long      = {1'b0, len_new} > CAP;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_q;
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    words_d     = words_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    if (take) begin
      case (state_q)
        IDLE: if (bus.rx_data == SYNC_BYTE) begin
          state_d = LEN_HI;
          sum_d   = 8'h00;
          words_d = '0;
        end
        LEN_HI: begin
          len_d[15:8] = bus.rx_data;
          sum_d       = sum_q + bus.rx_data;
          state_d     = LEN_LO;
        end
        LEN_LO: begin
          len_d   = len_new;
          sum_d   = sum_q + bus.rx_data;
          error_d = too_long;
          state_d = len_new == 16'd0 ? CHECK : too_long ? ERROR : DATA_HI;
        end
        DATA_HI: begin
          hi_d    = bus.rx_data;
          sum_d   = sum_q + bus.rx_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          rom_we_d    = 1'b1;
          rom_addr_d  = words_q[ADDR_WIDTH-1:0];
          rom_wdata_d = {hi_q, bus.rx_data};
          words_d     = words_inc;
          sum_d       = sum_q + bus.rx_data;
          state_d     = 17'(words_inc) == {1'b0, len_q} ? CHECK : DATA_HI;
        end
        CHECK: begin
          state_d     = chk_ok ? RUN : ERROR;
          done_d      = chk_ok;
          cpu_reset_d = !chk_ok;
          error_d     = !chk_ok;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      words_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      words_q     <= words_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: randomized frames checked each cycle against a byte-position model, plus literal checks
module tb_hack_rom_loader;
  localparam int         AW   = 4;
  localparam int         CAP  = 1 << AW;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_reset, done, error;
  logic [AW:0] words_loaded;
  hack_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();
  hack_rom_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
    .clock(clock), .reset(reset), .bus(bus), .cpu_reset(cpu_reset),
    .done(done), .error(error), .words_loaded(words_loaded));
  always #5 clock = ~clock;
  int total = 0, bad = 0, we_count = 0;
  bit started = 1'b0;
  bit m_in, m_done, m_err, m_we;
  int m_pos, m_len, m_sum, m_words, m_addr;
  logic [7:0]  m_hi;
  logic [15:0] m_wdata;
  logic [15:0] m_mem [CAP];
  logic [15:0] rom_cap [CAP];
  logic [15:0] fdata [CAP+1];
  logic [7:0]  txq [$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clock) if (bus.rom_we === 1'b1) begin
    rom_cap[bus.rom_addr] = bus.rom_wdata;
    we_count++;
  end
  // Model: interprets accepted bytes purely by their position within the frame.
  always @(posedge clock) begin
    if (reset) begin
      started = 1'b1; m_in = 0; m_done = 0; m_err = 0; m_we = 0;
      m_pos = 0; m_sum = 0; m_words = 0; m_addr = 0; m_wdata = 16'h0;
    end else begin
      m_we = 0;
      if (!m_done && !m_err && bus.rx_valid) begin
        automatic logic [7:0] b = bus.rx_data;
        if (!m_in) begin
          if (b == SYNC) begin m_in = 1; m_pos = 1; m_sum = 0; m_words = 0; end
        end else if (m_pos == 1) begin
          m_len = int'(b) * 256; m_sum += b; m_pos = 2;
        end else if (m_pos == 2) begin
          m_len += b; m_sum += b; m_pos = 3;
          if (m_len > CAP) m_err = 1;
        end else if (m_pos < 3 + 2 * m_len) begin
          automatic int idx = m_pos - 3;
          m_sum += b;
          if (idx % 2 == 0) m_hi = b;
          else begin
            m_we = 1; m_addr = idx / 2; m_wdata = {m_hi, b};
            m_mem[idx/2] = m_wdata; m_words = idx / 2 + 1;
          end
          m_pos++;
        end else if (b == 8'(m_sum)) m_done = 1;
        else m_err = 1;
      end
    end
  end
  always @(negedge clock) if (started) begin
    chk("rx_ready", bus.rx_ready, !(m_done || m_err));
    chk("rom_we", bus.rom_we, m_we);
    chk("rom_addr", bus.rom_addr, 32'(m_addr));
    chk("rom_wdata", bus.rom_wdata, m_wdata);
    chk("cpu_reset", cpu_reset, !m_done);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("words_loaded", words_loaded, 32'(m_words));
  end
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic do_reset();
    reset = 1'b1; bus.rx_valid = 1'b0;
    idle(2);
    reset = 1'b0; we_count = 0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b0;
    idle(gap);
    bus.rx_valid = 1'b1; bus.rx_data = b;
    idle(1);
    bus.rx_valid = 1'b0;
  endtask
  task automatic flush(input int gapmax);
    foreach (txq[i]) send(txq[i], $urandom_range(0, gapmax));
    txq.delete();
  endtask
  task automatic build_frame(input int len, input bit good);
    automatic logic [7:0] s = 8'(len >> 8) + 8'(len);
    txq.push_back(SYNC); txq.push_back(8'(len >> 8)); txq.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      txq.push_back(fdata[i][15:8]); txq.push_back(fdata[i][7:0]);
      s = s + fdata[i][15:8] + fdata[i][7:0];
    end
    txq.push_back(good ? s : s + 8'd1);
  endtask
  task automatic mem_check(input string n);
    for (int i = 0; i < CAP; i++) chk(n, rom_cap[i], m_mem[i]);
  endtask
  initial begin
    for (int i = 0; i < CAP; i++) begin rom_cap[i] = 16'h0; m_mem[i] = 16'h0; end
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h01};
    flush(0); idle(2);
    chk("t1_done", done, 1); chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_w0", rom_cap[0], 16'h0003); chk("t1_w1", rom_cap[1], 16'hEC10);
    chk("t1_words", words_loaded, 2); chk("t1_we", we_count, 2);
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h02, 8'hA5, 8'h00};
    flush(0); idle(2);
    chk("t2_error", error, 1); chk("t2_done", done, 0);
    chk("t2_cpu_reset", cpu_reset, 1); chk("t2_we", we_count, 2);
    do_reset();
    txq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h01};
    flush(0); idle(2);
    chk("t3_done", done, 1); chk("t3_w1", rom_cap[1], 16'hEC10);
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    flush(0); idle(2);
    chk("t4_done", done, 1); chk("t4_words", words_loaded, 0); chk("t4_we", we_count, 0);
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h03};
    flush(0);
    do_reset();
    chk("t5_cpu_reset", cpu_reset, 1);
    txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h01};
    flush(0); idle(2);
    chk("t5_done", done, 1);
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h11, 8'h00, 8'h01};
    flush(0); idle(2);
    chk("t6_error", error, 1); chk("t6_we", we_count, 0);
    do_reset();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h01};
    flush(3); idle(2);
    chk("t6_gap_done", done, 1); chk("t6_gap_w1", rom_cap[1], 16'hEC10);
    do_reset();
    for (int i = 0; i < CAP; i++) fdata[i] = 16'(i * 257 + 1);
    build_frame(CAP, 1'b1);
    flush(0); idle(2);
    chk("full_done", done, 1); chk("full_last", rom_cap[15], 16'h0F10);
    chk("full_words", words_loaded, 16);
    mem_check("full_mem");
    for (int it = 0; it < 40; it++) begin
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        automatic logic [7:0] nb = 8'($urandom);
        txq.push_back(nb == SYNC ? 8'h00 : nb);
      end
      for (int i = 0; i <= CAP; i++) fdata[i] = 16'($urandom);
      build_frame($urandom_range(0, CAP + 1), $urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) txq.push_back(8'($urandom));
      flush($urandom_range(0, 3)); idle(3);
      mem_check("rand_mem");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
